servo_pwm_driver: RTL and testbench

//  Downstream stage of the I-PD servo loop. Consumes the signed, truncated controller output
//  (cant_bits wide) and drives an H-bridge with sign-magnitude PWM: two drive pins in1/in2.

---
 rtl/servo_pwm_driver.sv | 178 +++++++++++++++++
 tb/tb_servo_pwm_driver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_driver.sv
// rtl/servo_pwm_driver.sv - sign-magnitude H-bridge PWM driver with period-aligned duty and reversal dead time
module servo_pwm_driver #(
    parameter int cant_bits   = 13,
    parameter int DEAD_CYCLES = 64,
    parameter int DEADBAND    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        run,
    input  logic signed [cant_bits-1:0] u,
    output logic                        in1,
    output logic                        in2,
    output logic                        period_tick,
    output logic                        dead,
    output logic                        sat
);

    localparam int CW = cant_bits - 1;
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0] DB        = CW'(DEADBAND);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           load_act;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  dcnt;
    logic           wrap;

    // decoded view of the incoming control word
    logic           u_neg;
    logic           u_min;
    logic [CW-1:0]  u_abs;
    logic [CW-1:0]  u_mag;
    state_t         u_dir;

    // shadow holds the latest strobed request, active holds the duty of the running period
    state_t         shadow_dir;
    logic [CW-1:0]  shadow_mag;
    logic           shadow_sat;
    logic [CW-1:0]  act_mag;
    logic           act_sat;

    assign wrap        = (cnt == CNT_MAX);
    assign period_tick = wrap;
    assign dead        = (state == ST_DEAD);
    assign sat         = act_sat;

    // Magnitude/direction decode; the most negative code clips to full scale and flags sat
    always_comb begin
        u_neg = u[cant_bits-1];
        u_min = u_neg && (u[CW-1:0] == '0);
        u_abs = u_neg ? (~u[CW-1:0] + 1'b1) : u[CW-1:0];
        u_mag = u_min ? CNT_MAX : u_abs;
        if (u_mag < DB) begin
            u_mag = '0;
        end
        if (u_mag == '0) begin
            u_dir = ST_STOP;
        end else if (u_neg) begin
            u_dir = ST_REV;
        end else begin
            u_dir = ST_FWD;
        end
    end

    // Shadow request register, loaded on every strobe regardless of run or state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_dir <= ST_STOP;
            shadow_mag <= '0;
            shadow_sat <= 1'b0;
        end else if (en) begin
            shadow_dir <= u_dir;
            shadow_mag <= u_mag;
            shadow_sat <= u_min;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_STOP;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: decisions only at period wraps, or when the dead interval expires
    always_comb begin
        state_nxt = state;
        load_act  = 1'b0;
        if (!run) begin
            state_nxt = ST_STOP;
        end else begin
            case (state)
                ST_STOP: begin
                    if (wrap) begin
                        state_nxt = shadow_dir;
                        load_act  = 1'b1;
                    end
                end
                ST_FWD: begin
                    if (wrap) begin
                        state_nxt = (shadow_dir == ST_REV) ? ST_DEAD : shadow_dir;
                        load_act  = 1'b1;
                    end
                end
                ST_REV: begin
                    if (wrap) begin
                        state_nxt = (shadow_dir == ST_FWD) ? ST_DEAD : shadow_dir;
                        load_act  = 1'b1;
                    end
                end
                default: begin
                    if (dcnt == DEAD_LAST) begin
                        state_nxt = shadow_dir;
                        load_act  = 1'b1;
                    end
                end
            endcase
        end
    end

    // Active duty copy, refreshed at wraps and at the end of a dead interval
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_mag <= '0;
            act_sat <= 1'b0;
        end else if (load_act) begin
            act_mag <= shadow_mag;
            act_sat <= shadow_sat;
        end
    end

    // Period counter: free-running, parked at 0 while stopped by run or during dead time
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (!run || state == ST_DEAD) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Dead-time counter, counts only while in DEAD
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dcnt <= '0;
        end else if (run && state == ST_DEAD && dcnt != DEAD_LAST) begin
            dcnt <= dcnt + 1'b1;
        end else begin
            dcnt <= '0;
        end
    end

    // Registered bridge pins; a single state value makes in1 and in2 mutually exclusive
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1 <= 1'b0;
            in2 <= 1'b0;
        end else begin
            in1 <= run && (state == ST_FWD) && (cnt < act_mag);
            in2 <= run && (state == ST_REV) && (cnt < act_mag);
        end
    end

endmodule

// File: tb/tb_servo_pwm_driver.sv
// tb/tb_servo_pwm_driver.sv - directed self-checking bench for servo_pwm_driver
module tb_servo_pwm_driver;

    localparam int PER = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en  = 1'b0;
    logic              run = 1'b0;
    logic signed [12:0] u  = '0;
    logic              in1, in2, period_tick, dead, sat;

    int ntotal = 0;
    int npass  = 0;
    int nfail  = 0;
    int both_err = 0;

    int h1, h2, nt, nd;
    int k;

    servo_pwm_driver #(.cant_bits(13), .DEAD_CYCLES(64), .DEADBAND(8)) dut (
        .clk(clk), .rst(rst), .en(en), .run(run), .u(u),
        .in1(in1), .in2(in2), .period_tick(period_tick), .dead(dead), .sat(sat)
    );

    always #5 clk = ~clk;

    // pins must never be high together, whether or not a clock edge is involved
    always @(in1 or in2) begin
        if (in1 && in2) both_err++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic measure(input int n);
        h1 = 0; h2 = 0; nt = 0; nd = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            h1 += int'(in1);
            h2 += int'(in2);
            nt += int'(period_tick);
            nd += int'(dead);
        end
    endtask

    task automatic wait_tick(input string tag);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!period_tick && c < 5000);
        check(tag, int'(period_tick), 1);
    endtask

    task automatic strobe(input int v);
        u  = 13'(v);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    // strobe mid-period and return on the tick that applies it
    task automatic apply(input int v, input string tag);
        repeat (100) @(negedge clk);
        strobe(v);
        wait_tick(tag);
    endtask

    initial begin
        // 1: reset state, then idle periods
        repeat (5) @(negedge clk);
        check("rst_in1", int'(in1), 0);
        check("rst_in2", int'(in2), 0);
        check("rst_tick", int'(period_tick), 0);
        check("rst_dead", int'(dead), 0);
        check("rst_sat", int'(sat), 0);
        rst = 1'b1;
        run = 1'b1;
        measure(3 * PER);
        check("idle_in1", h1, 0);
        check("idle_in2", h2, 0);
        check("idle_ticks", nt, 3);

        // 2: forward 1024
        wait_tick("t2_sync");
        apply(1024, "t2_tick");
        measure(PER);
        check("fwd1024_in1", h1, 1024);
        check("fwd1024_in2", h2, 0);
        check("fwd1024_dead", nd, 0);
        check("fwd1024_ticks", nt, 1);

        // 3: reversal mid-period with dead time
        measure(PER / 2);
        check("rev_pre_in1", h1, 1024);
        strobe(-2048);
        wait_tick("t3_tick");
        measure(64);
        check("dead_cnt", nd, 64);
        check("dead_in1", h1, 0);
        check("dead_in2", h2, 0);
        measure(PER);
        check("rev2048_in2", h2, 2048);
        check("rev2048_in1", h1, 0);
        check("rev2048_dead", nd, 0);

        // 4: clipped negative full scale, then deadband to stop
        apply(-4096, "t4_tick");
        measure(PER);
        check("sat_in2", h2, 4095);
        check("sat_in1", h1, 0);
        check("sat_flag", int'(sat), 1);
        apply(5, "t4b_tick");
        measure(PER);
        check("db_in1", h1, 0);
        check("db_in2", h2, 0);
        check("db_dead", nd, 0);
        check("db_sat", int'(sat), 0);

        // 5: last strobe wins, then DEAD ending in STOP
        repeat (100) @(negedge clk);
        strobe(100);
        apply(3000, "t5_tick");
        measure(PER);
        check("last_wins_in1", h1, 3000);
        check("last_wins_dead", nd, 0);
        apply(-500, "t5b_tick");
        strobe(0);
        check("dead_first", int'(dead), 1);
        measure(63);
        check("dead_rest", nd, 63);
        measure(PER);
        check("dead2stop_dead", nd, 0);
        check("dead2stop_in1", h1, 0);
        check("dead2stop_in2", h2, 0);

        // 6: async reset mid-high, run gating, run restart latency
        apply(3000, "t6_tick");
        repeat (1000) @(negedge clk);
        check("pre_rst_in1", int'(in1), 1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_in1", int'(in1), 0);
        check("async_rst_dead", int'(dead), 0);
        @(negedge clk);
        rst = 1'b1;
        measure(PER / 2);
        check("post_rst_in1", h1, 0);
        check("post_rst_in2", h2, 0);
        wait_tick("t6_sync");
        apply(3000, "t6b_tick");
        repeat (500) @(negedge clk);
        check("pre_run_in1", int'(in1), 1);
        run = 1'b0;
        @(negedge clk);
        check("run0_in1", int'(in1), 0);
        strobe(2000);
        measure(500);
        check("run0_hold_in1", h1, 0);
        check("run0_hold_ticks", nt, 0);
        run = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!in1 && k < 5000);
        check("restart_latency", k, PER + 1);
        measure(PER);
        check("restart_in1", h1, 2000);
        check("restart_in2", h2, 0);

        check("never_both", both_err, 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
